// File: rtl/keypad_scanner_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | keypad_pkg : shared types, matrix geometry and key codes for the scanner |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
package keypad_pkg;

  localparam int ROWS  = 4;
  localparam int COLS  = 3;
  localparam int ROW_W = $clog2(ROWS);
  localparam int COL_W = $clog2(COLS);

  localparam logic [3:0] KEY_STAR = 4'hA;
  localparam logic [3:0] KEY_HASH = 4'hB;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_EMIT     = 2'd2,
    ST_HOLD     = 2'd3
  } state_e;

  // Telephone layout: rows 0..2 hold 1..9, bottom row is '*', '0', '#'.
  function automatic logic [3:0] key_map(input logic [ROW_W-1:0] row,
                                         input logic [COL_W-1:0] col);
    logic [3:0] code;
    if (row == ROW_W'(ROWS - 1)) begin
      case (col)
        2'd0:    code = KEY_STAR;
        2'd1:    code = 4'd0;
        default: code = KEY_HASH;
      endcase
    end else begin
      code = 4'(row) * 4'd3 + 4'(col) + 4'd1;
    end
    return code;
  endfunction

  function automatic logic [ROWS-1:0] row_strobe(input logic [ROW_W-1:0] row);
    return ~(ROWS'(1) << row);
  endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_scanner_col_sync.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | col_sync : multi-bit flop synchronizer, resets to all-ones (released)    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module col_sync #(
  parameter int WIDTH  = 3,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o
);

  logic [STAGES-1:0][WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
    end
  end

  assign sync_o = sync_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | keypad_scanner : 4x3 matrix scan, debounce and one event per key press   |
// | Revision       : 1.0                                                     |
// +--------------------------------------------------------------------------+
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DWELL      = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SYNC_STAGES     = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [ROWS-1:0] row_drive,
  input  logic [COLS-1:0] col_sense,
  output logic [3:0]      key,
  output logic            pressed,
  output logic            set_code
);

  localparam int CNT_MAX = (SCAN_DWELL > DEBOUNCE_CYCLES) ? SCAN_DWELL : DEBOUNCE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DWELL_C  = CNT_W'(SCAN_DWELL);
  localparam logic [CNT_W-1:0] DEB_M1_C = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [COLS-1:0]  col_s;
  state_e           state_q;
  logic [ROW_W-1:0] row_q;
  logic [COL_W-1:0] col_q;
  logic [CNT_W-1:0] cnt_q;
  logic [ROWS-1:0]  row_drive_q;
  logic [3:0]       key_q;
  logic             pressed_q;
  logic             set_code_q;

  logic             hit;
  logic [COL_W-1:0] hit_col;
  logic [ROW_W-1:0] row_inc;
  logic [3:0]       code;
  logic             track_low;

  col_sync #(
    .WIDTH  (COLS),
    .STAGES (SYNC_STAGES)
  ) u_col_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (col_sense),
    .sync_o  (col_s)
  );

  // Descending scan so the lowest-index low column wins.
  always_comb begin
    hit     = 1'b0;
    hit_col = '0;
    for (int i = COLS - 1; i >= 0; i--) begin
      if (!col_s[i]) begin
        hit     = 1'b1;
        hit_col = COL_W'(i);
      end
    end
  end

  assign row_inc   = (row_q == ROW_W'(ROWS - 1)) ? '0 : row_q + 1'b1;
  assign code      = key_map(row_q, col_q);
  assign track_low = ~col_s[col_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_SCAN;
      row_q       <= '0;
      col_q       <= '0;
      cnt_q       <= '0;
      row_drive_q <= '1;
      key_q       <= '0;
      pressed_q   <= 1'b0;
      set_code_q  <= 1'b0;
    end else begin
      pressed_q  <= 1'b0;
      set_code_q <= 1'b0;
      unique case (state_q)
        ST_SCAN: begin
          if (cnt_q < DWELL_C) begin
            cnt_q       <= cnt_q + 1'b1;
            row_drive_q <= row_strobe(row_q);
          end else if (hit) begin
            state_q <= ST_DEBOUNCE;
            col_q   <= hit_col;
            cnt_q   <= CNT_W'(1);
          end else begin
            row_q       <= row_inc;
            cnt_q       <= CNT_W'(1);
            row_drive_q <= row_strobe(row_inc);
          end
        end
        ST_DEBOUNCE: begin
          if (!track_low) begin
            state_q     <= ST_SCAN;
            row_q       <= row_inc;
            cnt_q       <= CNT_W'(1);
            row_drive_q <= row_strobe(row_inc);
          end else if (cnt_q >= DEB_M1_C) begin
            // Pulse registers are loaded here so they are high during EMIT.
            state_q <= ST_EMIT;
            cnt_q   <= '0;
            if (code == KEY_HASH) begin
              set_code_q <= 1'b1;
            end else if (code != KEY_STAR) begin
              key_q     <= code;
              pressed_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_EMIT: begin
          state_q <= ST_HOLD;
          cnt_q   <= '0;
        end
        ST_HOLD: begin
          if (track_low) begin
            cnt_q <= '0;
          end else if (cnt_q >= DEB_M1_C) begin
            state_q     <= ST_SCAN;
            row_q       <= row_inc;
            cnt_q       <= CNT_W'(1);
            row_drive_q <= row_strobe(row_inc);
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= ST_SCAN;
      endcase
    end
  end

  assign row_drive = row_drive_q;
  assign key       = key_q;
  assign pressed   = pressed_q;
  assign set_code  = set_code_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_keypad_scanner : directed scoreboard bench with a key-matrix model    |
// | Revision          : 1.0                                                  |
// +--------------------------------------------------------------------------+
module tb_keypad_scanner;

  localparam int LAT_MAX = 4 * 4 + 2 + 4 + 1;

  typedef struct packed {
    logic       is_set;
    logic [3:0] key;
  } ev_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] row_drive;
  logic [2:0] col_sense;
  logic [3:0] key;
  logic       pressed;
  logic       set_code;

  logic [3:0][2:0] key_dn;
  ev_t             exp_q[$];
  int              checks;
  int              errors;
  int              n_events;
  logic            prev_pulse;

  keypad_scanner #(
    .SCAN_DWELL      (4),
    .DEBOUNCE_CYCLES (4),
    .SYNC_STAGES     (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row_drive (row_drive),
    .col_sense (col_sense),
    .key       (key),
    .pressed   (pressed),
    .set_code  (set_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Passive matrix: a held key pulls its column low while its row is strobed.
  always_comb begin
    col_sense = 3'b111;
    for (int r = 0; r < 4; r++) begin
      if (!row_drive[r]) col_sense = col_sense & ~key_dn[r];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (pressed || set_code) begin
      n_events++;
      chk("pulse_overlap", {31'd0, pressed & set_code}, 32'd0);
      chk("pulse_back_to_back", {31'd0, prev_pulse}, 32'd0);
      chk("unexpected_pulse", {31'd0, exp_q.size() > 0}, 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pulse_kind_set", {31'd0, set_code}, {31'd0, e.is_set});
        chk("pulse_key", {28'd0, key}, {28'd0, e.key});
      end
    end
    prev_pulse = pressed | set_code;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic await_event(input int base, input int max_lat);
    int  lat;
    logic got;
    got = 1'b0;
    lat = 0;
    for (int i = 1; i <= 80 && !got; i++) begin
      @(negedge clk);
      lat = i;
      if (n_events != base) got = 1'b1;
    end
    chk("event_timeout", {31'd0, got}, 32'd1);
    checks++;
    assert (lat <= max_lat) else begin
      errors++;
      $error("FAIL event_latency: observed=%0d cycles expected<=%0d", lat, max_lat);
    end
  endtask

  task automatic press_expect(input int r, input int c, input logic is_set, input logic [3:0] k);
    int base;
    exp_q.push_back('{is_set: is_set, key: k});
    base = n_events;
    key_dn[r][c] = 1'b1;
    await_event(base, LAT_MAX + 1);
  endtask

  task automatic release_key(input int r, input int c);
    key_dn[r][c] = 1'b0;
    tick(20);
  endtask

  task automatic wait_row(input logic [3:0] rd);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (row_drive == rd) seen = 1'b1;
    end
    chk("wait_row_timeout", {31'd0, seen}, 32'd1);
  endtask

  initial begin
    logic [3:0] exp_rd;
    int         base;
    int         cyc;
    checks     = 0;
    errors     = 0;
    n_events   = 0;
    prev_pulse = 1'b0;
    key_dn     = '0;
    rst_n      = 1'b0;

    // Reset state and idle scan order.
    tick(3);
    chk("reset_row_drive", {28'd0, row_drive}, 32'hF);
    chk("reset_key", {28'd0, key}, 32'd0);
    chk("reset_pressed", {31'd0, pressed}, 32'd0);
    chk("reset_set_code", {31'd0, set_code}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      exp_rd = ~(4'b0001 << (i / 4));
      chk("idle_row_drive", {28'd0, row_drive}, {28'd0, exp_rd});
    end
    chk("idle_no_events", n_events, 32'd0);

    // Clean press of '5': row stays strobed while held, scan resumes at row 2.
    press_expect(1, 1, 1'b0, 4'd5);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("hold_row_drive", {28'd0, row_drive}, 32'hD);
    end
    key_dn[1][1] = 1'b0;
    cyc = 0;
    for (int i = 1; i <= 30 && row_drive == 4'b1101; i++) begin
      @(negedge clk);
      cyc = i;
    end
    chk("release_next_row", {28'd0, row_drive}, 32'hB);
    checks++;
    assert (cyc >= 4) else begin
      errors++;
      $error("FAIL release_debounce: observed=%0d cycles expected>=4", cyc);
    end
    tick(20);

    // Bounce on '9' before a steady press.
    key_dn[2][2] = 1'b1;
    tick(2);
    key_dn[2][2] = 1'b0;
    tick(1);
    press_expect(2, 2, 1'b0, 4'd9);
    tick(10);
    release_key(2, 2);

    // Digit sequence, then '#', then '*'.
    press_expect(0, 0, 1'b0, 4'd1);  tick(5); release_key(0, 0);
    press_expect(0, 1, 1'b0, 4'd2);  tick(5); release_key(0, 1);
    press_expect(0, 2, 1'b0, 4'd3);  tick(5); release_key(0, 2);
    press_expect(1, 0, 1'b0, 4'd4);  tick(5); release_key(1, 0);
    press_expect(3, 2, 1'b1, 4'd4);  tick(5); release_key(3, 2);
    chk("key_after_hash", {28'd0, key}, 32'd4);
    base = n_events;
    key_dn[3][0] = 1'b1;
    tick(60);
    release_key(3, 0);
    chk("star_no_event", n_events, base);
    chk("key_after_star", {28'd0, key}, 32'd4);

    // Reset while '7' is being debounced.
    wait_row(4'b1110);
    key_dn[2][0] = 1'b1;
    wait_row(4'b1011);
    tick(5);
    base  = n_events;
    rst_n = 1'b0;
    #1;
    chk("async_reset_row_drive", {28'd0, row_drive}, 32'hF);
    tick(2);
    key_dn[2][0] = 1'b0;
    tick(1);
    rst_n = 1'b1;
    chk("post_reset_key", {28'd0, key}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      exp_rd = ~(4'b0001 << (i / 4));
      chk("post_reset_row_drive", {28'd0, row_drive}, {28'd0, exp_rd});
    end
    tick(30);
    chk("reset_discards_press", n_events, base);

    // '0' and '#' together: '0' wins, '#' follows once '0' is released.
    key_dn[3][2] = 1'b1;
    press_expect(3, 1, 1'b0, 4'd0);
    tick(10);
    exp_q.push_back('{is_set: 1'b1, key: 4'd0});
    base = n_events;
    key_dn[3][1] = 1'b0;
    await_event(base, 60);
    tick(5);
    release_key(3, 2);

    tick(10);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
